// File: rtl/arbiter_rr_param.sv
// ---------------------------------------------------------------------------
// arbiter_rr_param
//
// Parametrised round-robin arbiter with a registered grant. A grant is held
// until its owner pulses i_rel or drops its request. Priority then rotates to
// the index after the old owner, so no requester starves while others keep
// requesting.
//
// Parameters
//   N         number of requesters (2..32)
//   ID_W      width of o_gnt_id; the value N encodes "no grant"
//   MAX_HOLD  longest grant in cycles (>= 2), used only with ARB_TIMEOUT_EN
//
// Optional feature
//   ARB_TIMEOUT_EN  when defined, a hold counter force-releases any grant
//                   held for MAX_HOLD cycles and pulses o_timeout. When it
//                   is undefined, o_timeout is tied low and grants are
//                   unbounded.
//
// Ports
//   i_clk      rising-edge clock
//   i_rst      asynchronous active-high reset
//   i_req      request vector, bit i = requester i wants the resource
//   i_rel      release strobe from the current owner (ignored while idle)
//   o_gnt_vld  a grant is active
//   o_gnt_id   index of the owner, N when idle
//   o_gnt_oh   one-hot grant, all zeros when idle
//   o_timeout  one-cycle pulse after a forced release
// ---------------------------------------------------------------------------
module arbiter_rr_param #(
  parameter int N        = 4,
  parameter int ID_W     = $clog2(N + 1),
  parameter int MAX_HOLD = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N-1:0]    i_req,
  input  logic            i_rel,
  output logic            o_gnt_vld,
  output logic [ID_W-1:0] o_gnt_id,
  output logic [N-1:0]    o_gnt_oh,
  output logic            o_timeout
);

  localparam logic [ID_W-1:0] NO_GNT = ID_W'(N);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t          r_state, w_stateNxt;
  logic [ID_W-1:0] r_ptr, w_ptrNxt;
  logic [ID_W-1:0] r_gntId, w_gntIdNxt;
  logic [N-1:0]    r_gntOh, w_gntOhNxt;
  logic            r_gntVld;
  logic            r_timeout, w_timeoutNxt;

  logic            w_ownReq;
  logic [N-1:0]    w_cand;
  logic            w_natRel;
  logic            w_forceRel;
  logic            w_release;
  logic            w_newGrant;
  logic            w_found;
  int              w_start;
  int              w_best;
  int              w_bestDist;
  int              w_dist;

  // Illegal parameter combinations stop elaboration.
  if (N < 2 || N > 32 || MAX_HOLD < 2) begin : g_badParams
    $error("arbiter_rr_param: N must be 2..32 and MAX_HOLD >= 2");
  end

  // Pick out the owner's own request line and build the candidate set.
  // While a grant is active the owner is masked, so a release always hands
  // over to somebody else (or goes idle).
  always_comb begin
    w_ownReq = 1'b0;
    w_cand   = '0;
    for (int i = 0; i < N; i++) begin
      if (r_state == ST_GRANT && int'(r_gntId) == i) begin
        w_ownReq = i_req[i];
      end else begin
        w_cand[i] = i_req[i];
      end
    end
  end

  // A natural release is a rel strobe or a dropped request; both together
  // count once.
  assign w_natRel  = (r_state == ST_GRANT) && (i_rel || !w_ownReq);
  assign w_release = w_natRel || w_forceRel;

  // Round-robin search: the winner is the candidate closest to the start
  // index, measured as forward distance modulo N. On a release the search
  // starts just past the old owner, which is also the new pointer value.
  always_comb begin
    w_start    = (r_state == ST_GRANT) ? (int'(r_gntId) + 1) % N : int'(r_ptr);
    w_best     = N;
    w_bestDist = N;
    w_dist     = 0;
    for (int i = 0; i < N; i++) begin
      w_dist = (i + N - w_start) % N;
      if (w_cand[i] && w_dist < w_bestDist) begin
        w_bestDist = w_dist;
        w_best     = i;
      end
    end
    w_found = (w_best != N);
  end

  // Next-state and next-output logic for the IDLE/GRANT machine.
  always_comb begin
    w_stateNxt   = r_state;
    w_ptrNxt     = r_ptr;
    w_gntIdNxt   = r_gntId;
    w_timeoutNxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_gntIdNxt = NO_GNT;
        if (w_found) begin
          w_stateNxt = ST_GRANT;
          w_gntIdNxt = ID_W'(w_best);
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_ptrNxt     = ID_W'(w_start);
          w_timeoutNxt = w_forceRel;
          if (w_found) begin
            w_gntIdNxt = ID_W'(w_best);
          end else begin
            w_stateNxt = ST_IDLE;
            w_gntIdNxt = NO_GNT;
          end
        end
      end
      default: begin
        w_stateNxt = ST_IDLE;
        w_gntIdNxt = NO_GNT;
      end
    endcase
  end

  // The one-hot output is the decode of the next owner index, so it stays
  // consistent with o_gnt_id by construction.
  always_comb begin
    w_gntOhNxt = '0;
    for (int i = 0; i < N; i++) begin
      w_gntOhNxt[i] = (int'(w_gntIdNxt) == i);
    end
  end

  assign w_newGrant = (w_stateNxt == ST_GRANT) && (r_state == ST_IDLE || w_release);

`ifdef ARB_TIMEOUT_EN
  localparam int HC_W = $clog2(MAX_HOLD);

  logic [HC_W-1:0] r_holdCnt;

  // A forced release fires on the last permitted grant cycle, only when the
  // owner is not already letting go on its own.
  assign w_forceRel = (r_state == ST_GRANT) && !w_natRel &&
                      (r_holdCnt == HC_W'(MAX_HOLD - 1));

  // Hold counter: zero in the first cycle of every grant, counting up while
  // the same grant persists.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_holdCnt <= '0;
    end else if (w_newGrant || r_state != ST_GRANT) begin
      r_holdCnt <= '0;
    end else begin
      r_holdCnt <= r_holdCnt + 1'b1;
    end
  end
`else
  assign w_forceRel = 1'b0;
`endif

  // State and output registers. Reset clears everything immediately, even
  // in the middle of a grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_gntId   <= NO_GNT;
      r_gntOh   <= '0;
      r_gntVld  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_stateNxt;
      r_ptr     <= w_ptrNxt;
      r_gntId   <= w_gntIdNxt;
      r_gntOh   <= w_gntOhNxt;
      r_gntVld  <= (w_gntIdNxt != NO_GNT);
      r_timeout <= w_timeoutNxt;
    end
  end

  assign o_gnt_vld = r_gntVld;
  assign o_gnt_id  = r_gntId;
  assign o_gnt_oh  = r_gntOh;
  assign o_timeout = r_timeout;

endmodule

// File: doc/arbiter_rr_param.md
Name: arbiter_rr_param

Overview:
- Parametrised round-robin arbiter. Successor to the 4-input fixed-priority arbiter.
- Scales to N requesters and registers the grant.
- A grant is held until the owner releases it.
- Rotates priority so that no requester starves.
- Sits between N request sources and one shared resource (bus, port or memory).

Parameters:
- N, 4, number of requesters; legal range 2..32.
- ID_W, $clog2(N+1), width of gnt_id; value N encodes "no grant".
- MAX_HOLD, 16, maximum cycles a grant may be held; used only when ARB_TIMEOUT_EN is defined; must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector; bit i = requester i wants the resource.
- rel  input  1  release strobe from the current owner; sampled only while gnt_vld=1.
- gnt_vld  output  1  a grant is active.
- gnt_id  output  ID_W  index of the owner; equals N when there is no grant.
- gnt_oh  output  N  one-hot grant; all zeros when there is no grant.
- timeout  output  1  one-cycle pulse when a grant is force-released (ARB_TIMEOUT_EN only).

Behaviour:
- Reset (async assert, sync deassert by clk domain):
  - state=IDLE, ptr=0, hold_cnt=0.
  - gnt_vld=0, gnt_id=N, gnt_oh=0, timeout=0.
  - Reset asserted mid-grant clears all outputs immediately; no release handshake.
- All outputs are registered. Latency from req sampled to grant visible is 1 cycle.
- ptr is the highest-priority index. Search order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
- IDLE:
  - If |req: winner w = first set bit in search order. Next cycle: state=GRANT, gnt_id=w, gnt_oh=1<<w, gnt_vld=1.
  - Else: stay in IDLE with outputs at their reset values.
- GRANT, hold condition:
  - Hold while req[gnt_id]=1 and rel=0. gnt_id is stable and other requests are ignored.
- GRANT, release condition: rel=1, or req[gnt_id]=0 (request dropped).
  - ptr <= (gnt_id+1) mod N; wrap from N-1 goes to 0.
  - Winner is searched among req with bit gnt_id masked, starting from the new ptr.
  - If a winner exists: next cycle grants it (back-to-back handover, no idle cycle).
  - If no winner: next cycle state=IDLE, gnt_id=N.
  - A lone requester that is still requesting after rel is therefore regranted after exactly one IDLE cycle.
- Simultaneous rel and req[gnt_id]=0: treated as a single release.
- rel while in IDLE: ignored.
- gnt_oh always equals the decode of gnt_id (zero when gnt_id=N). gnt_vld = (gnt_id != N).
- Fairness: with all N requesting and each owner releasing, every requester is granted once per N grants.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt (width $clog2(MAX_HOLD)) clears on each new grant and increments every GRANT cycle.
  - When hold_cnt==MAX_HOLD-1 and there is no natural release, the arbiter forces a release using the normal release rules.
  - timeout=1 for exactly one cycle, aligned with the first cycle after the forced release (new grant or IDLE).
  - A grant therefore lasts at most MAX_HOLD cycles.
- Undefined: no counter is built, timeout is tied to 0, and a grant can be held indefinitely.

Test Plan:
1. Reset: rst=1 mid-grant with N=4 -> same cycle gnt_vld=0, gnt_id=4, gnt_oh=0000; after rst=0 with req=0000 -> outputs stay at reset values.
2. Basic: ptr=0, req=0101 -> next cycle gnt_id=0, gnt_oh=0001; pulse rel -> next cycle gnt_id=2, gnt_oh=0100; rel again with req=0000 -> gnt_id=4.
3. Rotation: req=1111 held, rel pulsed on every grant cycle -> gnt_id sequence 0,1,2,3,0,1 with no idle cycles.
4. Hold and drop: req=0011, grant 0, rel=0 for 10 cycles -> gnt_id stays 0; drop req[0] -> next cycle gnt_id=1; lone req=0010 with rel -> IDLE for one cycle, then gnt_id=1.
5. Wrap: grant 3 with req=1001, rel -> ptr wraps, next gnt_id=0.
6. Timeout (ARB_TIMEOUT_EN, MAX_HOLD=8): req=0011, no rel -> gnt_id=0 for exactly 8 cycles, then gnt_id=1 with timeout=1 for one cycle.
